// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// Stage k resolves BPS carry-select blocks; the final stage register drives the outputs.
module pipe_csel_adder #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = WIDTH / BLK;
  localparam int BPS  = NBLK / STAGES;
  localparam int LAST = STAGES - 1;
  // Inter-stage register count; kept at least 1 so the arrays stay legal when STAGES == 1.
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic             c;
    logic [WIDTH-1:0] sum;
  } stage_res_t;

  // One pipeline stage: BPS blocks, each precomputing both carry-in cases and
  // selecting with the carry rippling in from the block below.
  function automatic stage_res_t stage_add(
    input int               k,
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [WIDTH-1:0] sum_in,
    input logic             c_in
  );
    stage_res_t   r;
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    int           base;
    r.c   = c_in;
    r.sum = sum_in;
    for (int j = 0; j < BPS; j++) begin
      base = (k * BPS + j) * BLK;
      s0   = {1'b0, op_a[base +: BLK]} + {1'b0, op_b[base +: BLK]};
      s1   = {1'b0, op_a[base +: BLK]} + {1'b0, op_b[base +: BLK]} + {{BLK{1'b0}}, 1'b1};
      r.sum[base +: BLK] = r.c ? s1[BLK-1:0] : s0[BLK-1:0];
      r.c  = s0[BLK] | (s1[BLK] & r.c);
    end
    return r;
  endfunction

  logic             stall;
  logic             ovf_d;
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];
  logic             st_v   [STAGES];
  stage_res_t       res    [STAGES];

  logic             reg_v   [NREG];
  logic             reg_c   [NREG];
  logic [WIDTH-1:0] reg_sum [NREG];
  logic [WIDTH-1:0] reg_a   [NREG];
  logic [WIDTH-1:0] reg_b   [NREG];

  // A stalled output freezes the whole pipe; an empty output slot never stalls.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // NOTE: every variable this block writes gets a value on every pass, so no latch is inferred.
  always_comb begin
    st_a[0]   = a;
    st_b[0]   = sub ? ~b : b;
    st_sum[0] = '0;
    st_c[0]   = ci ^ sub;
    st_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = reg_a[k-1];
      st_b[k]   = reg_b[k-1];
      st_sum[k] = reg_sum[k-1];
      st_c[k]   = reg_c[k-1];
      st_v[k]   = reg_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res[k] = stage_add(k, st_a[k], st_b[k], st_sum[k], st_c[k]);
    end
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    ovf_d = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ res[LAST].sum[WIDTH-1] ^ res[LAST].c;
  end

  // NOTE: state is updated with <= so each stage captures the previous stage's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) reg_v[k] <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < LAST; k++) reg_v[k] <= st_v[k];
      out_valid <= st_v[LAST];
      s         <= res[LAST].sum;
      co        <= res[LAST].c;
      ovf       <= ovf_d;
      zero      <= ~|res[LAST].sum;
    end
  end

  // NOTE: inter-stage payload has no reset; a slot's valid bit alone decides whether it is live.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 0; k < LAST; k++) begin
        reg_c[k]   <= res[k].c;
        reg_sum[k] <= res[k].sum;
        reg_a[k]   <= st_a[k];
        reg_b[k]   <= st_b[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Scoreboard bench: directed and random traffic on the default configuration plus random
// traffic on four other parameter sets, all checked against a plain-arithmetic model.
module tb_pipe_csel_adder;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } exp_t;

  localparam int N_RAND   = 10000;
  localparam int R_BUDGET = 45000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [63:0] s_v, input logic co_v, ovf_v, zero_v);
    exp_t e;
    e.s    = s_v;
    e.co   = co_v;
    e.ovf  = ovf_v;
    e.zero = zero_v;
    return e;
  endfunction

  // Reference: exact unsigned and signed integer results, then range tests for co / ovf.
  function automatic exp_t ref_model(input int w, input logic [63:0] op_a, op_b,
                                     input logic op_ci, op_sub);
    logic signed [67:0] pow_w, pow_h, ua, ub, sa, sb, cin, ut, st;
    logic [63:0]        mask;
    exp_t               e;
    pow_w = 68'sd1 <<< w;
    pow_h = 68'sd1 <<< (w - 1);
    mask  = 64'(pow_w - 68'sd1);
    ua    = {4'b0, op_a & mask};
    ub    = {4'b0, op_b & mask};
    cin   = {67'b0, op_ci};
    sa    = (ua >= pow_h) ? ua - pow_w : ua;
    sb    = (ub >= pow_h) ? ub - pow_w : ub;
    if (op_sub) begin
      ut   = ua - ub - cin;
      st   = sa - sb - cin;
      e.co = (ut >= 68'sd0);
    end else begin
      ut   = ua + ub + cin;
      st   = sa + sb + cin;
      e.co = (ut >= pow_w);
    end
    e.s    = ut[63:0] & mask;
    e.ovf  = (st >= pow_h) || (st < -pow_h);
    e.zero = (e.s == 64'd0);
    return e;
  endfunction

  // ---------------- default-parameter DUT ----------------
  logic        rst_d  = 1'b1;
  logic        d_iv   = 1'b0;
  logic        d_ci   = 1'b0;
  logic        d_sub  = 1'b0;
  logic        d_ordy = 1'b1;
  logic [31:0] d_a    = '0;
  logic [31:0] d_b    = '0;
  logic        d_ir, d_ov, d_co, d_ovf, d_zero;
  logic [31:0] d_s;
  exp_t        d_q[$];
  int          d_got = 0;
  bit          m_rand_done = 1'b0;

  pipe_csel_adder u_dut (
    .clk(clk), .rst(rst_d), .in_valid(d_iv), .in_ready(d_ir),
    .a(d_a), .b(d_b), .ci(d_ci), .sub(d_sub),
    .out_valid(d_ov), .out_ready(d_ordy),
    .s(d_s), .co(d_co), .ovf(d_ovf), .zero(d_zero)
  );

  initial begin : d_monitor
    exp_t        e;
    logic        was_stall = 1'b0;
    logic [31:0] held_s    = '0;
    logic [2:0]  held_f    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (was_stall) begin
        check("hold_s", 64'(d_s), 64'(held_s));
        check("hold_flags", 64'({d_ov, d_co, d_ovf, d_zero}), 64'({1'b1, held_f}));
      end
      if (d_ov && d_ordy && !rst_d) begin
        if (d_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got s=0x%0h with no result outstanding (t=%0t)", d_s, $time);
        end else begin
          e = d_q.pop_front();
          d_got++;
          check("s", 64'(d_s), e.s);
          check("co", 64'(d_co), 64'(e.co));
          check("ovf", 64'(d_ovf), 64'(e.ovf));
          check("zero", 64'(d_zero), 64'(e.zero));
        end
      end
      was_stall = d_ov && !d_ordy && !rst_d;
      held_s    = d_s;
      held_f    = {d_co, d_ovf, d_zero};
    end
  end

  task automatic send_op(input logic [31:0] ta, tb, input logic tci, tsub, input exp_t e);
    int tries = 0;
    @(negedge clk);
    d_a   = ta;
    d_b   = tb;
    d_ci  = tci;
    d_sub = tsub;
    d_iv  = 1'b1;
    #1;
    while (!d_ir && tries < 100) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (d_ir) d_q.push_back(e);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b, want 1 (t=%0t)", d_ir, $time);
    end
  endtask

  task automatic drain_main();
    int t = 0;
    d_ordy = 1'b1;
    while (d_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    #3;
    check("drain", 64'(d_q.size()), 64'd0);
  endtask

  // ---------------- random harness over several parameter sets ----------------
  logic rst_r = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W = (g == 3) ? 64 : (g == 2) ? 16 : 32;
    localparam int B = (g == 3) ? 8 : 4;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 4 : 2;

    logic         r_iv   = 1'b0;
    logic         r_ci   = 1'b0;
    logic         r_sub  = 1'b0;
    logic         r_ordy = 1'b0;
    logic [W-1:0] r_a    = '0;
    logic [W-1:0] r_b    = '0;
    logic         r_ir, r_ov, r_co, r_ovf, r_zero;
    logic [W-1:0] r_s;
    exp_t         q[$];
    bit           done = 1'b0;

    pipe_csel_adder #(.WIDTH(W), .BLK(B), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst_r), .in_valid(r_iv), .in_ready(r_ir),
      .a(r_a), .b(r_b), .ci(r_ci), .sub(r_sub),
      .out_valid(r_ov), .out_ready(r_ordy),
      .s(r_s), .co(r_co), .ovf(r_ovf), .zero(r_zero)
    );

    initial begin : driver
      int   sent = 0;
      int   cyc  = 0;
      logic pend = 1'b0;
      while (rst_r) @(negedge clk);
      while ((sent < N_RAND || q.size() != 0) && cyc < R_BUDGET) begin
        @(negedge clk);
        cyc++;
        r_ordy = (sent >= N_RAND) || ($urandom_range(0, 3) != 0);
        if (!pend) begin
          if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
            r_a   = W'({$urandom, $urandom});
            r_b   = W'({$urandom, $urandom});
            r_ci  = 1'($urandom_range(0, 1));
            r_sub = 1'($urandom_range(0, 1));
            r_iv  = 1'b1;
            pend  = 1'b1;
          end else begin
            r_iv = 1'b0;
          end
        end
        #1;
        if (r_iv && r_ir) begin
          q.push_back(ref_model(W, 64'(r_a), 64'(r_b), r_ci, r_sub));
          sent++;
          pend = 1'b0;
        end
      end
      #3;
      check($sformatf("cfg%0d_sent", g), 64'(sent), 64'(N_RAND));
      check($sformatf("cfg%0d_drained", g), 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    initial begin : monitor
      exp_t         e;
      logic         was_stall = 1'b0;
      logic [W-1:0] held_s    = '0;
      logic [2:0]   held_f    = '0;
      forever begin
        @(negedge clk);
        #2;
        if (was_stall) begin
          check($sformatf("cfg%0d_hold_s", g), 64'(r_s), 64'(held_s));
          check($sformatf("cfg%0d_hold_flags", g), 64'({r_ov, r_co, r_ovf, r_zero}), 64'({1'b1, held_f}));
        end
        if (r_ov && r_ordy) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL cfg%0d_unexpected_out: got s=0x%0h with no result outstanding", g, r_s);
          end else begin
            e = q.pop_front();
            check($sformatf("cfg%0d_s", g), 64'(r_s), e.s);
            check($sformatf("cfg%0d_flags", g), 64'({r_co, r_ovf, r_zero}), 64'({e.co, e.ovf, e.zero}));
          end
        end
        was_stall = r_ov && !r_ordy;
        held_s    = r_s;
        held_f    = {r_co, r_ovf, r_zero};
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] ta, tbv;
    logic        tci, tsub;
    int          lat;
    int          g0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(d_ir), 64'd1);
    check("rst_out_valid", 64'(d_ov), 64'd0);
    check("rst_s", 64'(d_s), 64'd0);
    check("rst_flags", 64'({d_co, d_ovf, d_zero}), 64'd0);
    @(negedge clk);
    rst_d = 1'b0;
    rst_r = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(d_ir), 64'd1);

    // Carry out of all ones, with latency measured from the accepting edge.
    send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk_exp(64'h0, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    d_iv = 1'b0;
    lat  = 1;
    #1;
    while (!d_ov && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd2);
    drain_main();

    // Subtract with and without borrow-in, signed overflow both ways, zero difference.
    send_op(32'h5, 32'h7, 1'b0, 1'b1, mk_exp(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send_op(32'h5, 32'h7, 1'b1, 1'b1, mk_exp(64'hFFFF_FFFD, 1'b0, 1'b0, 1'b0));
    send_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk_exp(64'h8000_0000, 1'b0, 1'b1, 1'b0));
    send_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, mk_exp(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send_op(32'h0, 32'h0, 1'b0, 1'b1, mk_exp(64'h0, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    d_iv = 1'b0;
    drain_main();

    // Eight back-to-back ops with a three-cycle consumer stall after the second result.
    g0 = d_got;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ta   = $urandom;
          tbv  = $urandom;
          tci  = 1'($urandom_range(0, 1));
          tsub = 1'($urandom_range(0, 1));
          send_op(ta, tbv, tci, tsub, ref_model(32, 64'(ta), 64'(tbv), tci, tsub));
        end
        @(negedge clk);
        d_iv = 1'b0;
      end
      begin
        int t = 0;
        while (d_got < g0 + 2 && t < 50) begin
          @(negedge clk);
          #3;
          t++;
        end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          d_ordy = 1'b0;
          #1;
          check("stall_in_ready", 64'(d_ir), 64'd0);
          check("stall_out_valid", 64'(d_ov), 64'd1);
        end
        @(negedge clk);
        d_ordy = 1'b1;
      end
    join
    drain_main();
    check("stream_count", 64'(d_got - g0), 64'd8);

    // Reset while two ops are in flight: neither may ever appear.
    @(negedge clk);
    d_a  = 32'h1234_5678;
    d_b  = 32'h1111_1111;
    d_iv = 1'b1;
    #1;
    check("flush_accept", 64'(d_ir), 64'd1);
    @(negedge clk);
    d_a   = 32'hDEAD_BEEF;
    rst_d = 1'b1;
    #1;
    check("flush_rst_in_ready", 64'(d_ir), 64'd1);
    @(negedge clk);
    rst_d = 1'b0;
    d_iv  = 1'b0;
    #1;
    check("flush_s", 64'(d_s), 64'd0);
    check("flush_flags", 64'({d_co, d_ovf, d_zero}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("flush_out_valid", 64'(d_ov), 64'd0);
      @(negedge clk);
      #1;
    end
    send_op(32'h3, 32'h4, 1'b0, 1'b0, mk_exp(64'h7, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    d_iv = 1'b0;
    drain_main();

    // Random traffic with a randomly back-pressuring consumer.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ta   = $urandom;
          tbv  = $urandom;
          tci  = 1'($urandom_range(0, 1));
          tsub = 1'($urandom_range(0, 1));
          send_op(ta, tbv, tci, tsub, ref_model(32, 64'(ta), 64'(tbv), tci, tsub));
          if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            d_iv = 1'b0;
          end
        end
        @(negedge clk);
        d_iv        = 1'b0;
        m_rand_done = 1'b1;
      end
      begin
        while (!m_rand_done) begin
          @(negedge clk);
          if (!m_rand_done) d_ordy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain_main();

    for (int t = 0; t < 50000 &&
         !(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done); t++) begin
      @(negedge clk);
    end
    check("cfg_done", 64'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done, g_cfg[3].done}), 64'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
